// File: rtl/bank_burst_scheduler.sv
// Round-robin bank arbiter feeding burst_handler with same-row, same-type request bursts.
// Optional macro ROW_HIT_PRIO_EN: banks whose head row matches their last opened row win first.
module bank_burst_scheduler #(
  parameter int NUM_BANKS      = 16,
  parameter int MAX_BURST_REQS = 4,
  parameter int DATA_W         = 32,
  parameter int IDX_W          = 4,
  parameter int ADDR_W         = 32,
  parameter int COL_W          = 10,
  parameter int ROW_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_BANKS-1:0]               req_valid,
  output logic [NUM_BANKS-1:0]               req_ready,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]   req_address,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]   req_data,
  input  logic [NUM_BANKS-1:0][IDX_W-1:0]    req_index,
  input  logic [NUM_BANKS-1:0]               req_type,
  input  logic                               start_new_burst,
  output logic                               arbiter_valid,
  output logic [ADDR_W-1:0]                  in_req_address,
  output logic [DATA_W-1:0]                  arbiter_data,
  output logic [IDX_W-1:0]                   arbiter_index,
  output logic                               arbiter_type_temp
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = $clog2(MAX_BURST_REQS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t              state;
  logic [BANK_W-1:0]   rr_ptr;
  logic [BANK_W-1:0]   grant_bank;
  logic [ROW_W-1:0]    grant_row;
  logic                grant_type;
  logic [CNT_W-1:0]    burst_cnt;

  logic [NUM_BANKS-1:0] cand;
  logic                 win_found;
  logic [BANK_W-1:0]    win_bank;
  logic                 idle_pop;
  logic                 stream_pop;
  logic                 pop;
  logic [BANK_W-1:0]    pop_bank;

`ifdef ROW_HIT_PRIO_EN
  logic [NUM_BANKS-1:0][ROW_W-1:0] open_row;
  logic [NUM_BANKS-1:0]            open_row_vld;
  logic [NUM_BANKS-1:0]            row_hit;

  // Row hits form the candidate set when any exist; otherwise every valid bank competes.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      row_hit[b] = req_valid[b] && open_row_vld[b] &&
                   (req_address[b][COL_W +: ROW_W] == open_row[b]);
    end
    cand = (|row_hit) ? row_hit : req_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_row     <= '0;
      open_row_vld <= '0;
    end else if (idle_pop) begin
      open_row[win_bank]     <= req_address[win_bank][COL_W +: ROW_W];
      open_row_vld[win_bank] <= 1'b1;
    end
  end
`else
  assign cand = req_valid;
`endif

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_bank  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      j = (int'(rr_ptr) + i) % NUM_BANKS;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_bank  = BANK_W'(j);
      end
    end
  end

  // Pops are masked during reset so no request is consumed while the pipeline is cleared.
  always_comb begin
    idle_pop   = rst_n && (state == IDLE) && start_new_burst && win_found;
    stream_pop = (state == STREAM) && req_valid[grant_bank] &&
                 (req_address[grant_bank][COL_W +: ROW_W] == grant_row) &&
                 (req_type[grant_bank] == grant_type) &&
                 (burst_cnt < CNT_W'(MAX_BURST_REQS));
    pop        = idle_pop || stream_pop;
    pop_bank   = idle_pop ? win_bank : grant_bank;
    req_ready  = '0;
    if (pop) req_ready[pop_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant_bank        <= '0;
      grant_row         <= '0;
      grant_type        <= 1'b0;
      burst_cnt         <= '0;
      arbiter_valid     <= 1'b0;
      in_req_address    <= '0;
      arbiter_data      <= '0;
      arbiter_index     <= '0;
      arbiter_type_temp <= 1'b0;
    end else begin
      arbiter_valid <= pop;
      if (pop) begin
        in_req_address    <= req_address[pop_bank];
        arbiter_data      <= req_data[pop_bank];
        arbiter_index     <= req_index[pop_bank];
        arbiter_type_temp <= req_type[pop_bank];
      end
      case (state)
        IDLE: begin
          if (idle_pop) begin
            grant_bank <= win_bank;
            grant_row  <= req_address[win_bank][COL_W +: ROW_W];
            grant_type <= req_type[win_bank];
            burst_cnt  <= CNT_W'(1);
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (stream_pop) burst_cnt <= burst_cnt + CNT_W'(1);
          else            state     <= GAP;
        end
        GAP: begin
          rr_ptr    <= (grant_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : grant_bank + BANK_W'(1);
          burst_cnt <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_burst_scheduler.sv
// Bench for bank_burst_scheduler: bank queues and a burst-level model drive per-cycle checks.
`timescale 1ns/1ps
module tb_bank_burst_scheduler;

  localparam int NUM_BANKS = 16, MAX_BURST_REQS = 4, DATA_W = 32, IDX_W = 4;
  localparam int ADDR_W = 32, COL_W = 10, ROW_W = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              typ;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_BANKS-1:0]             req_valid;
  logic [NUM_BANKS-1:0]             req_ready;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] req_address;
  logic [NUM_BANKS-1:0][DATA_W-1:0] req_data;
  logic [NUM_BANKS-1:0][IDX_W-1:0]  req_index;
  logic [NUM_BANKS-1:0]             req_type;
  logic                             start_new_burst;
  logic                             arbiter_valid;
  logic [ADDR_W-1:0]                in_req_address;
  logic [DATA_W-1:0]                arbiter_data;
  logic [IDX_W-1:0]                 arbiter_index;
  logic                             arbiter_type_temp;

  bank_burst_scheduler #(
    .NUM_BANKS(NUM_BANKS), .MAX_BURST_REQS(MAX_BURST_REQS), .DATA_W(DATA_W),
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_data(req_data), .req_index(req_index),
    .req_type(req_type), .start_new_burst(start_new_burst),
    .arbiter_valid(arbiter_valid), .in_req_address(in_req_address),
    .arbiter_data(arbiter_data), .arbiter_index(arbiter_index),
    .arbiter_type_temp(arbiter_type_temp)
  );

  always #5 clk = ~clk;

  req_t bank_q [NUM_BANKS][$];
  int checks = 0;
  int errors = 0;

  int               m_bank;
  int               m_cnt;
  int               m_rr;
  bit               m_gap;
  logic [ROW_W-1:0] m_row;
  logic             m_type;
  logic [ROW_W-1:0] m_open_row [NUM_BANKS];
  bit               m_open_vld [NUM_BANKS];

  logic              exp_valid;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [IDX_W-1:0]  exp_idx;
  logic              exp_type;

  int valid_trace[$];
  int ready_trace[$];
  int issued_idx[$];
  int issued_type[$];
  int burst_lens[$];

  function automatic logic [ROW_W-1:0] rowOf(input logic [ADDR_W-1:0] a);
    return a[COL_W +: ROW_W];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int b, input int row, input int col, input int idx, input bit typ);
    req_t r;
    r.addr = ADDR_W'(row) << COL_W | ADDR_W'(col);
    r.data = $urandom;
    r.idx  = IDX_W'(idx);
    r.typ  = typ;
    bank_q[b].push_back(r);
  endtask

  // Round-robin search from the model pointer, optionally restricted to open-row hits.
  function automatic int rrPick(input bit hit_only);
    for (int i = 0; i < NUM_BANKS; i++) begin
      int b = (m_rr + i) % NUM_BANKS;
      if (bank_q[b].size() > 0 &&
          (!hit_only || (m_open_vld[b] && rowOf(bank_q[b][0].addr) == m_open_row[b])))
        return b;
    end
    return -1;
  endfunction

  task automatic modelCycle(input bit start, output int pop);
    int pick;
    pop = -1;
    if (m_bank >= 0) begin
      if (bank_q[m_bank].size() > 0 && rowOf(bank_q[m_bank][0].addr) == m_row &&
          bank_q[m_bank][0].typ == m_type && m_cnt < MAX_BURST_REQS) begin
        pop = m_bank;
        m_cnt++;
      end else begin
        m_rr   = (m_bank + 1) % NUM_BANKS;
        m_bank = -1;
        m_gap  = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (start) begin
      pick = -1;
`ifdef ROW_HIT_PRIO_EN
      pick = rrPick(1'b1);
`endif
      if (pick < 0) pick = rrPick(1'b0);
      if (pick >= 0) begin
        pop    = pick;
        m_bank = pick;
        m_cnt  = 1;
        m_row  = rowOf(bank_q[pick][0].addr);
        m_type = bank_q[pick][0].typ;
        m_open_row[pick] = m_row;
        m_open_vld[pick] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit start);
    @(negedge clk);
    start_new_burst = start;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q[b].size() > 0) begin
        req_valid[b]   = 1'b1;
        req_address[b] = bank_q[b][0].addr;
        req_data[b]    = bank_q[b][0].data;
        req_index[b]   = bank_q[b][0].idx;
        req_type[b]    = bank_q[b][0].typ;
      end else begin
        req_valid[b]   = 1'b0;
        req_address[b] = $urandom;
        req_data[b]    = $urandom;
        req_index[b]   = IDX_W'($urandom);
        req_type[b]    = 1'($urandom);
      end
    end
  endtask

  task automatic checkOutput(input int exp_pop);
    logic [NUM_BANKS-1:0] exp_ready;
    exp_ready = '0;
    if (exp_pop >= 0) exp_ready[exp_pop] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("arbiter_valid", 64'(arbiter_valid), 64'(exp_valid));
    chk("in_req_address", 64'(in_req_address), 64'(exp_addr));
    chk("arbiter_data", 64'(arbiter_data), 64'(exp_data));
    chk("arbiter_index", 64'(arbiter_index), 64'(exp_idx));
    chk("arbiter_type_temp", 64'(arbiter_type_temp), 64'(exp_type));
  endtask

  task automatic step(input bit start);
    int pop;
    applyStimulus(start);
    #1;
    modelCycle(start, pop);
    checkOutput(pop);
    valid_trace.push_back(int'(arbiter_valid));
    ready_trace.push_back(int'(req_ready));
    if (arbiter_valid) begin
      issued_idx.push_back(int'(arbiter_index));
      issued_type.push_back(int'(arbiter_type_temp));
    end
    if (pop >= 0) begin
      exp_valid = 1'b1;
      exp_addr  = bank_q[pop][0].addr;
      exp_data  = bank_q[pop][0].data;
      exp_idx   = bank_q[pop][0].idx;
      exp_type  = bank_q[pop][0].typ;
      void'(bank_q[pop].pop_front());
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic modelReset();
    m_bank = -1; m_cnt = 0; m_rr = 0; m_gap = 1'b0; m_row = '0; m_type = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      m_open_row[b] = '0;
      m_open_vld[b] = 1'b0;
      bank_q[b].delete();
    end
    exp_valid = 1'b0; exp_addr = '0; exp_data = '0; exp_idx = '0; exp_type = 1'b0;
  endtask

  // Reset is asserted between clock edges so the outputs must clear without a clock.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_valid", 64'(arbiter_valid), 64'(0));
    chk("reset_address", 64'(in_req_address), 64'(0));
    chk("reset_data", 64'(arbiter_data), 64'(0));
    chk("reset_index", 64'(arbiter_index), 64'(0));
    chk("reset_type", 64'(arbiter_type_temp), 64'(0));
    modelReset();
    req_valid = '0;
    start_new_burst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clearTrace();
    valid_trace.delete(); ready_trace.delete();
    issued_idx.delete(); issued_type.delete(); burst_lens.delete();
  endtask

  task automatic computeBursts();
    int run;
    run = 0;
    burst_lens.delete();
    foreach (valid_trace[i]) begin
      if (valid_trace[i] != 0) run++;
      else if (run > 0) begin burst_lens.push_back(run); run = 0; end
    end
    if (run > 0) burst_lens.push_back(run);
  endtask

  task automatic runSteps(input int n, input bit start);
    for (int i = 0; i < n; i++) step(start);
  endtask

  initial begin
    int first_gap;
    int seen_valid;
    rst_n = 1'b0;
    req_valid = '0; req_address = '0; req_data = '0; req_index = '0; req_type = '0;
    start_new_burst = 1'b0;
    modelReset();

    doReset();
    clearTrace();
    push(0, 5, 0, 0, 1'b0);
    push(0, 5, 5, 2, 1'b0);
    runSteps(8, 1'b1);
    computeBursts();
    chk("t1_burst_count", 64'(burst_lens.size()), 64'(1));
    chk("t1_burst_len", 64'(burst_lens[0]), 64'(2));
    chk("t1_first_index", 64'(issued_idx[0]), 64'(0));
    chk("t1_second_index", 64'(issued_idx[1]), 64'(2));
    chk("t1_valid_timing", 64'(valid_trace[1] + 2 * valid_trace[2] + 4 * valid_trace[3]), 64'(3));

    doReset();
    clearTrace();
    push(0, 1, 0, 0, 1'b0);
    push(3, 1, 0, 3, 1'b0);
    push(7, 1, 0, 7, 1'b0);
    runSteps(16, 1'b1);
    computeBursts();
    chk("t2_burst_count", 64'(burst_lens.size()), 64'(3));
    chk("t2_order", 64'(issued_idx[0] * 256 + issued_idx[1] * 16 + issued_idx[2]), 64'(12'h037));
    chk("t2_model_rr", 64'(m_rr), 64'(8));
    first_gap = 0;
    seen_valid = 0;
    foreach (valid_trace[i]) begin
      if (valid_trace[i] != 0 && seen_valid == 0) seen_valid = 1;
      else if (valid_trace[i] == 0 && seen_valid == 1) first_gap++;
      else if (valid_trace[i] != 0 && seen_valid == 1) break;
    end
    chk("t2_gap_at_least_one", 64'(first_gap >= 1), 64'(1));

    doReset();
    clearTrace();
    for (int i = 0; i < 6; i++) push(2, 7, i, i, 1'b0);
    runSteps(16, 1'b1);
    computeBursts();
    chk("t3_burst_count", 64'(burst_lens.size()), 64'(2));
    chk("t3_first_burst", 64'(burst_lens[0]), 64'(MAX_BURST_REQS));
    chk("t3_second_burst", 64'(burst_lens[1]), 64'(2));
    chk("t3_last_index", 64'(issued_idx[5]), 64'(5));

    doReset();
    clearTrace();
    push(1, 4, 0, 1, 1'b0);
    push(1, 4, 1, 2, 1'b1);
    runSteps(10, 1'b1);
    computeBursts();
    chk("t4_burst_count", 64'(burst_lens.size()), 64'(2));
    chk("t4_type_first", 64'(issued_type[0]), 64'(0));
    chk("t4_type_second", 64'(issued_type[1]), 64'(1));

    doReset();
    clearTrace();
    push(5, 2, 0, 5, 1'b0);
    runSteps(3, 1'b0);
    runSteps(3, 1'b1);
    chk("t5_no_pop_while_low", 64'(ready_trace[0] | ready_trace[1] | ready_trace[2]), 64'(0));
    chk("t5_valid_low", 64'(valid_trace[3]), 64'(0));
    chk("t5_pop_on_raise", 64'(ready_trace[3]), 64'(32));
    chk("t5_valid_after_pop", 64'(valid_trace[4]), 64'(1));

    doReset();
    clearTrace();
    for (int i = 0; i < 4; i++) push(2, 3, i, i, 1'b0);
    runSteps(2, 1'b1);
    doReset();
    push(4, 9, 0, 4, 1'b0);
    runSteps(6, 1'b1);
    push(15, 3, 0, 15, 1'b0);
    runSteps(6, 1'b1);
    chk("t6_model_rr_wrapped", 64'(m_rr), 64'(0));
    clearTrace();
    push(0, 1, 0, 0, 1'b0);
    push(4, 9, 1, 4, 1'b0);
    runSteps(10, 1'b1);
`ifdef ROW_HIT_PRIO_EN
    chk("t6_row_hit_first", 64'(issued_idx[0]), 64'(4));
`else
    chk("t6_rr_first", 64'(issued_idx[0]), 64'(0));
`endif

    doReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 900 == 450) doReset();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          int b;
          b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NUM_BANKS - 1);
          if (bank_q[b].size() < 6)
            push(b, $urandom_range(0, 2), $urandom_range(0, 1023),
                 $urandom_range(0, 15), ($urandom_range(0, 4) == 0));
        end
      end
      step($urandom_range(0, 9) < 7);
    end
    runSteps(60, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
